// File: rtl/arith_unit_seq_if.sv
// ============================================================================
//  Module      : arith_unit_seq_if
//  Description : Request/result bundle for the sequential arithmetic unit.
//                The master drives operands, opcode and the request strobe;
//                the slave returns ready, the registered result and flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arith_unit_seq_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         alu_fun;
  logic               arith_en;
  logic               ready;
  logic [2*WIDTH-1:0] reg_arith;
  logic               reg_flag;
  logic               div_zero;
  logic               ovf_flag;

  modport master (
    output a, b, alu_fun, arith_en,
    input  ready, reg_arith, reg_flag, div_zero, ovf_flag
  );

  modport slave (
    input  a, b, alu_fun, arith_en,
    output ready, reg_arith, reg_flag, div_zero, ovf_flag
  );
endinterface

`default_nettype wire

// File: rtl/arith_unit_seq.sv
// ============================================================================
//  Module      : arith_unit_seq
//  Description : Sequential signed arithmetic unit. Add/sub/mul finish in one
//                cycle; divide is a WIDTH-cycle restoring divider returning
//                {remainder, quotient}. Optional multiply-accumulate is
//                enabled by defining the macro ARITH_MAC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_unit_seq #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  arith_unit_seq_if.slave    bus
);

  localparam int         CNT_W  = $clog2(WIDTH+1);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
`ifdef ARITH_MAC_EN
  localparam logic [3:0] OP_MAC = 4'b0100;
  localparam logic [3:0] OP_CLR = 4'b0101;
`endif

  // Elaboration-time parameter sanity checks
  if (WIDTH < 4) begin : g_bad_width
    $error("arith_unit_seq: WIDTH must be >= 4");
  end
  if (ACC_WIDTH < 2*WIDTH) begin : g_bad_acc_width
    $error("arith_unit_seq: ACC_WIDTH must be >= 2*WIDTH");
  end

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;

  state_t             state, state_next;

  // Result registers
  logic [2*WIDTH-1:0] reg_arith;
  logic               reg_flag;
  logic               div_zero;
  logic               ovf_flag;

  // Divider registers: magnitudes, signs and iteration counter
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quot_r;
  logic [WIDTH-1:0]   dvs_r;
  logic               a_neg_r;
  logic               q_neg_r;
  logic               ovf_cap_r;
  logic [CNT_W-1:0]   cnt_r;

  // Control / next-value signals from the combinational process
  logic               res_we;
  logic [2*WIDTH-1:0] res_val;
  logic               dz_val;
  logic               ov_val;
  logic               div_start;

  // Sign-extended operands and the exact 2*WIDTH product
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               accept;

  assign a_ext  = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
  assign b_ext  = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign prod   = $signed(a_ext) * $signed(b_ext);
  assign a_mag  = bus.a[WIDTH-1] ? (WIDTH'(0) - bus.a) : bus.a;
  assign b_mag  = bus.b[WIDTH-1] ? (WIDTH'(0) - bus.b) : bus.b;
  assign accept = bus.arith_en && (state == S_IDLE);

  // One restoring step: shift in the next dividend bit, subtract if it fits
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic               fits;
  logic [WIDTH-1:0]   rem_step, quot_step, quot_fix, rem_fix;

  always_comb begin
    rem_shift = {rem_r, quot_r[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dvs_r};
    fits      = (rem_shift >= {1'b0, dvs_r});
    rem_step  = fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quot_step = {quot_r[WIDTH-2:0], fits};
    quot_fix  = q_neg_r ? (WIDTH'(0) - quot_step) : quot_step;
    rem_fix   = a_neg_r ? (WIDTH'(0) - rem_step)  : rem_step;
  end

`ifdef ARITH_MAC_EN
  logic [ACC_WIDTH-1:0] acc_r, acc_next, prod_acc, acc_sum;
  logic                 acc_we, acc_ovf;

  assign prod_acc = {{(ACC_WIDTH-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign acc_sum  = acc_r + prod_acc;
  assign acc_ovf  = (acc_r[ACC_WIDTH-1] == prod_acc[ACC_WIDTH-1]) &&
                    (acc_sum[ACC_WIDTH-1] != acc_r[ACC_WIDTH-1]);
`endif

  // Next-state and result selection
  always_comb begin
    state_next = state;
    res_we     = 1'b0;
    res_val    = '0;
    dz_val     = 1'b0;
    ov_val     = 1'b0;
    div_start  = 1'b0;
`ifdef ARITH_MAC_EN
    acc_we     = 1'b0;
    acc_next   = acc_r;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (bus.alu_fun)
            OP_ADD: begin res_we = 1'b1; res_val = a_ext + b_ext; end
            OP_SUB: begin res_we = 1'b1; res_val = a_ext - b_ext; end
            OP_MUL: begin res_we = 1'b1; res_val = prod;          end
            OP_DIV: begin
              if (bus.b == '0) begin
                res_we = 1'b1;
                dz_val = 1'b1;
              end else begin
                div_start  = 1'b1;
                state_next = S_DIV;
              end
            end
`ifdef ARITH_MAC_EN
            OP_MAC: begin
              acc_we   = 1'b1;
              acc_next = acc_sum;
              res_we   = 1'b1;
              res_val  = acc_sum[2*WIDTH-1:0];
              ov_val   = acc_ovf;
            end
            OP_CLR: begin
              acc_we   = 1'b1;
              acc_next = '0;
              res_we   = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      S_DIV: begin
        if (cnt_r == CNT_W'(1)) begin
          res_we     = 1'b1;
          res_val    = {rem_fix, quot_fix};
          ov_val     = ovf_cap_r;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Result registers and divider datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_arith <= '0;
      reg_flag  <= 1'b0;
      div_zero  <= 1'b0;
      ovf_flag  <= 1'b0;
      rem_r     <= '0;
      quot_r    <= '0;
      dvs_r     <= '0;
      a_neg_r   <= 1'b0;
      q_neg_r   <= 1'b0;
      ovf_cap_r <= 1'b0;
      cnt_r     <= '0;
    end else begin
      reg_flag <= res_we;
      if (res_we) begin
        reg_arith <= res_val;
        div_zero  <= dz_val;
        ovf_flag  <= ov_val;
      end
      if (div_start) begin
        rem_r     <= '0;
        quot_r    <= a_mag;
        dvs_r     <= b_mag;
        a_neg_r   <= bus.a[WIDTH-1];
        q_neg_r   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        ovf_cap_r <= (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
        cnt_r     <= CNT_W'(WIDTH);
      end else if (state == S_DIV) begin
        rem_r  <= rem_step;
        quot_r <= quot_step;
        cnt_r  <= cnt_r - CNT_W'(1);
      end
    end
  end

`ifdef ARITH_MAC_EN
  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst)         acc_r <= '0;
    else if (acc_we) acc_r <= acc_next;
  end
`endif

  assign bus.ready     = (state == S_IDLE);
  assign bus.reg_arith = reg_arith;
  assign bus.reg_flag  = reg_flag;
  assign bus.div_zero  = div_zero;
  assign bus.ovf_flag  = ovf_flag;

endmodule

`default_nettype wire

// File: tb/tb_arith_unit_seq.sv
// ============================================================================
//  Module      : tb_arith_unit_seq
//  Description : Directed self-checking bench for arith_unit_seq (WIDTH=16).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arith_unit_seq;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  arith_unit_seq_if #(.WIDTH(WIDTH)) bus ();

  arith_unit_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] fun, input logic [15:0] av, input logic [15:0] bv);
    bus.alu_fun  = fun;
    bus.a        = av;
    bus.b        = bv;
    bus.arith_en = 1'b1;
  endtask

  // Issue a divide, wait (bounded) for its pulse; lat counts cycles from request
  task automatic run_div(input logic [15:0] av, input logic [15:0] bv, output int lat);
    drive(4'b0011, av, bv);
    tick();
    bus.arith_en = 1'b0;
    lat = 1;
    while (!bus.reg_flag && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int low_cycles;
  int pulses;
  logic [31:0] held;

  initial begin
    bus.a        = '0;
    bus.b        = '0;
    bus.alu_fun  = '0;
    bus.arith_en = 1'b0;

    // Reset held for two cycles
    rst = 1'b1;
    tick();
    tick();
    check("rst_arith", bus.reg_arith, 32'h0);
    check("rst_flag",  bus.reg_flag, 1'b0);
    check("rst_ready", bus.ready, 1'b1);
    check("rst_dz",    bus.div_zero, 1'b0);
    check("rst_ovf",   bus.ovf_flag, 1'b0);
    rst = 1'b0;
    tick();

    // add then mul on consecutive cycles, then sub
    drive(4'b0000, 16'hFFFB, 16'h0003);
    tick();
    check("add_flag",  bus.reg_flag, 1'b1);
    check("add_val",   bus.reg_arith, 32'hFFFFFFFE);
    drive(4'b0010, 16'hFFFB, 16'h0003);
    tick();
    check("mul_flag",  bus.reg_flag, 1'b1);
    check("mul_val",   bus.reg_arith, 32'hFFFFFFF1);
    check("mul_ovf",   bus.ovf_flag, 1'b0);
    drive(4'b0001, 16'hFFFB, 16'h0003);
    tick();
    check("sub_val",   bus.reg_arith, 32'hFFFFFFF8);
    drive(4'b0000, 16'h7FFF, 16'h7FFF);
    tick();
    check("add_max",   bus.reg_arith, 32'h0000FFFE);
    drive(4'b0010, 16'h8000, 16'h8000);
    tick();
    check("mul_min",   bus.reg_arith, 32'h40000000);
    bus.arith_en = 1'b0;
    tick();
    check("pulse_end", bus.reg_flag, 1'b0);

    // div -7/2 with an ignored request mid-division
    drive(4'b0011, 16'hFFF9, 16'h0002);
    tick();
    lat        = 1;
    low_cycles = 0;
    while (!bus.reg_flag && lat < 40) begin
      if (!bus.ready) low_cycles++;
      if (lat == 5) drive(4'b0000, 16'h0001, 16'h0001);
      else          bus.arith_en = 1'b0;
      tick();
      lat++;
    end
    check("div_lat",   lat, 17);
    check("div_busy",  low_cycles, 16);
    check("div_val",   bus.reg_arith, 32'hFFFFFFFD);
    check("div_ready", bus.ready, 1'b1);
    check("div_dz",    bus.div_zero, 1'b0);
    bus.arith_en = 1'b0;
    tick();
    check("div_nopend", bus.reg_flag, 1'b0);

    // More quotient/remainder sign cases
    run_div(16'd100, 16'd7, lat);
    check("div_pos",   bus.reg_arith, 32'h0002000E);
    run_div(16'd7, 16'hFFFE, lat);
    check("div_negb",  bus.reg_arith, 32'h0001FFFD);

    // Divide by zero
    drive(4'b0011, 16'd123, 16'h0000);
    tick();
    bus.arith_en = 1'b0;
    check("dz_flag",   bus.reg_flag, 1'b1);
    check("dz_dz",     bus.div_zero, 1'b1);
    check("dz_val",    bus.reg_arith, 32'h0);
    check("dz_ready",  bus.ready, 1'b1);

    // Most-negative / -1 overflow
    run_div(16'h8000, 16'hFFFF, lat);
    check("ovf_lat",   lat, 17);
    check("ovf_val",   bus.reg_arith, 32'h00008000);
    check("ovf_flag",  bus.ovf_flag, 1'b1);
    check("ovf_dz",    bus.div_zero, 1'b0);

    // Unsupported opcode: no pulse, result holds
    tick();
    held = 32'h00008000;
    drive(4'b0111, 16'd5, 16'd5);
    tick();
    bus.arith_en = 1'b0;
    check("bad_flag",  bus.reg_flag, 1'b0);
    check("bad_hold",  bus.reg_arith, held);

    // Reset during division: no pulse afterwards
    drive(4'b0011, 16'd1000, 16'd3);
    tick();
    bus.arith_en = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_ready", bus.ready, 1'b1);
    check("mid_flag",  bus.reg_flag, 1'b0);
    check("mid_arith", bus.reg_arith, 32'h0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.reg_flag) pulses++;
    end
    check("mid_nopulse", pulses, 0);

`ifdef ARITH_MAC_EN
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 16'd1000, 16'd1000);
      tick();
    end
    bus.arith_en = 1'b0;
    check("mac_flag",  bus.reg_flag, 1'b1);
    check("mac_val",   bus.reg_arith, 32'd3000000);
    check("mac_ovf",   bus.ovf_flag, 1'b0);
    drive(4'b0101, 16'd0, 16'd0);
    tick();
    bus.arith_en = 1'b0;
    check("clr_flag",  bus.reg_flag, 1'b1);
    check("clr_val",   bus.reg_arith, 32'h0);
    drive(4'b0100, 16'hFFFE, 16'd3);
    tick();
    bus.arith_en = 1'b0;
    check("mac_neg",   bus.reg_arith, 32'hFFFFFFFA);
`else
    drive(4'b0100, 16'd1000, 16'd1000);
    tick();
    bus.arith_en = 1'b0;
    check("mac_off",   bus.reg_flag, 1'b0);
    check("mac_hold",  bus.reg_arith, 32'h0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
